stream_frame_router: RTL and testbench
======================================

Name: stream_frame_router

Overview:
- Downstream stage of the beat-counting pass-through stage: consumes its DW-bit stream, cuts it into frames of FRAME_SIZE beats and routes whole frames alternately to two outputs (ping = m0, pong = m1) with tlast on each frame's final beat.
- Adds real backpressure via a 2-entry skid buffer (output register + skid register), so upstream sees a registered tready.
- An enable input gates the start of new frames only, never mid-frame.

Parameters:
- DW, 128, data width of all stream ports.
- FRAME_SIZE, 256, beats per frame; legal range >= 1.
- CW, 32, width of frame_count.

Ports:
- clk  input  1  clock, all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- enable  input  1  permits starting a new input frame.
- s_axis_tdata  input  DW  input beat data.
- s_axis_tvalid  input  1  input beat valid.
- s_axis_tready  output  1  input ready, registered.
- m0_axis_tdata  output  DW  ping output data.
- m0_axis_tvalid  output  1  ping output valid.
- m0_axis_tlast  output  1  last beat of a ping frame.
- m0_axis_tready  input  1  ping output ready.
- m1_axis_tdata / m1_axis_tvalid / m1_axis_tlast  output  DW/1/1  pong output, same semantics as m0.
- m1_axis_tready  input  1  pong output ready.
- active_path  output  1  0 = frames currently routed to m0, 1 = to m1.
- frame_count  output  CW  frames fully delivered, i.e. tlast beat accepted.
- in_beat_idx  output  clog2(FRAME_SIZE) (min 1)  input-side beat index within the current frame.

Behaviour:
- Reset, synchronous on resetn=0: all tvalid=0, tlast=0, tdata=0, s_axis_tready=0, active_path=0, frame_count=0, in_beat_idx=0. Skid and output registers are emptied and the output beat counter is cleared. A partially delivered frame is discarded; no further tlast is emitted for it.
- The first cycle after reset release has s_axis_tready=0. It rises on the next cycle when enable=1.
- Handshake:
  - A beat transfers when tvalid && tready are both high in the same cycle.
  - tvalid never drops and tdata/tlast never change while tvalid=1 and tready=0.
- Data path:
  - Latency is 1 cycle from input acceptance to output valid when the output register is empty.
  - Full throughput of 1 beat/clk while the selected output's tready=1.
  - When the output stalls, an accepted beat parks in the skid register.
  - s_axis_tready(next) = skid empty after this cycle AND NOT gated. It is never asserted with the skid full.
  - Order is strictly preserved.
- Input-side gating (in_beat_idx counter, increments on each input handshake, wraps FRAME_SIZE-1 -> 0):
  - While in_beat_idx==0 and enable=0, s_axis_tready=0 (frame boundary hold).
  - enable=0 mid-frame has no effect until the frame's last beat is accepted.
- Output FSM, 2 states, with an output beat counter out_idx:
  - S_PING: only m0_axis_tvalid may assert; m1 is idle. m0_axis_tlast = (out_idx == FRAME_SIZE-1).
  - S_PONG: mirror image on m1.
  - Transition: on the handshake of the tlast beat, out_idx -> 0, the state toggles, active_path toggles, and frame_count increments. All three update in the same cycle.
  - The tready of the non-selected output is ignored entirely.
- frame_count wraps 2^CW-1 -> 0 with no flag.
- FRAME_SIZE=1: every beat carries tlast, and paths alternate every beat.
- Simultaneous input accept and output drain in the same cycle: the beat moves straight into the output register and the skid stays empty.
- Reset asserted mid-frame overrides all other events that cycle.

Decomposition:
- Shared package: a path-select enum (PATH_PING=0, PATH_PONG=1), the FSM state encoding, and a clog2-based width helper for beat indices.
- One natural sub-module: axis_skid_buffer, a 2-entry DW-wide register slice with registered tready. The router instantiates it and keeps the FSM, counters and demux.

Test Plan (all with FRAME_SIZE=4, DW=128):
1. Reset then 8 back-to-back beats 0..7, both treadys=1:
   - m0 gets 0..3 with tlast on beat 3; m1 gets 4..7 with tlast on beat 7.
   - frame_count=2, active_path=0.
   - First output valid appears 1 cycle after the first acceptance.
2. m0_axis_tready held 0 for 5 cycles mid-frame:
   - s_axis_tready drops within 2 accepted beats; no beat is lost or duplicated.
   - m0 tdata/tvalid stay stable throughout the stall.
   - Sequence resumes intact when tready returns.
3. enable=0 asserted on beat 1 of a frame:
   - Beats 2,3 are still accepted, then s_axis_tready=0 with in_beat_idx=0.
   - Raising enable resumes acceptance within 1 cycle.
4. m1_axis_tready toggling randomly during a ping frame: no effect on m0 delivery; m1_axis_tvalid stays 0.
5. resetn pulsed low after 2 beats of frame 0:
   - All valids=0, frame_count=0, active_path=0.
   - The next 4 beats go to m0 with tlast on the 4th.
6. CW=4, 17 frames streamed: frame_count wraps 15 -> 0 -> 1, and active_path ends at 1.

Source files
------------

// File: rtl/stream_frame_router_pkg.sv
// Shared types and helpers for the stream frame router.
//   path_e    : output path select (ping = m0, pong = m1)
//   state_e   : output FSM state encoding
//   idx_width : width of a beat index for a given frame size (minimum 1 bit)
package stream_frame_router_pkg;

  typedef enum logic {
    PATH_PING = 1'b0,
    PATH_PONG = 1'b1
  } path_e;

  typedef enum logic {
    StPing = 1'b0,
    StPong = 1'b1
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice (output register + skid register) with a
// registered upstream ready.
//   clk, resetn      : clock, synchronous active-low reset
//   hold             : suppress ready for the next cycle (frame-boundary gating)
//   s_data/s_valid   : upstream beat; s_ready is a pure flop output
//   m_data/m_valid   : downstream beat from the output register
//   m_ready          : downstream ready
module axis_skid_buffer #(
  parameter int unsigned DW = 128
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          hold,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready
);

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic          ready_q, ready_d;
  logic          s_hs;

  assign s_hs = s_valid && ready_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || m_ready) begin
      // Output register frees up this cycle: refill from skid first to keep order.
      // ready_q is only high while the skid is empty, so skid and s_hs never collide.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (s_hs) begin
        out_valid_d = 1'b1;
        out_data_d  = s_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (s_hs) begin
      // Output stalled: park the accepted beat.
      skid_valid_d = 1'b1;
      skid_data_d  = s_data;
    end
    ready_d = !skid_valid_d && !hold;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
    end
  end

  assign s_ready = ready_q;
  assign m_valid = out_valid_q;
  assign m_data  = out_data_q;

endmodule

// File: rtl/stream_frame_router.sv
// Cuts an incoming stream into frames of FRAME_SIZE beats and routes whole
// frames alternately to m0 (ping) and m1 (pong), marking each frame's final
// beat with tlast. New input frames only start while enable is high.
//   clk, resetn          : clock, synchronous active-low reset
//   enable               : permits starting a new input frame
//   s_axis_*             : input stream, tready registered
//   m0_axis_*, m1_axis_* : ping / pong output streams
//   active_path          : path the current output frame is routed to
//   frame_count          : frames fully delivered (tlast beat accepted), wraps
//   in_beat_idx          : input-side beat index within the current frame
module stream_frame_router
  import stream_frame_router_pkg::*;
#(
  parameter int unsigned DW         = 128,
  parameter int unsigned FRAME_SIZE = 256,
  parameter int unsigned CW         = 32
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                enable,
  input  logic [DW-1:0]                       s_axis_tdata,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  output logic [DW-1:0]                       m0_axis_tdata,
  output logic                                m0_axis_tvalid,
  output logic                                m0_axis_tlast,
  input  logic                                m0_axis_tready,
  output logic [DW-1:0]                       m1_axis_tdata,
  output logic                                m1_axis_tvalid,
  output logic                                m1_axis_tlast,
  input  logic                                m1_axis_tready,
  output logic                                active_path,
  output logic [CW-1:0]                       frame_count,
  output logic [idx_width(FRAME_SIZE)-1:0]    in_beat_idx
);

  localparam int unsigned   IW      = idx_width(FRAME_SIZE);
  localparam logic [IW-1:0] LastIdx = IW'(FRAME_SIZE - 1);
  localparam logic [IW-1:0] OneIdx  = IW'(1);

  state_e        state_q, state_d;
  logic [IW-1:0] out_idx_q, out_idx_d;
  logic [IW-1:0] in_idx_q, in_idx_d;
  logic [CW-1:0] frame_count_q, frame_count_d;

  logic          hold;
  logic          s_hs;
  logic          buf_valid;
  logic [DW-1:0] buf_data;
  logic          sel_ready;
  logic          m_hs;
  logic          out_last;
  path_e         path_sel;

  axis_skid_buffer #(
    .DW(DW)
  ) u_skid (
    .clk    (clk),
    .resetn (resetn),
    .hold   (hold),
    .s_data (s_axis_tdata),
    .s_valid(s_axis_tvalid),
    .s_ready(s_axis_tready),
    .m_data (buf_data),
    .m_valid(buf_valid),
    .m_ready(sel_ready)
  );

  assign s_hs     = s_axis_tvalid && s_axis_tready;
  // Non-selected output's tready never influences the datapath.
  assign sel_ready = (state_q == StPing) ? m0_axis_tready : m1_axis_tready;
  assign m_hs     = buf_valid && sel_ready;
  assign out_last = (out_idx_q == LastIdx);

  always_comb begin
    state_d       = state_q;
    out_idx_d     = out_idx_q;
    in_idx_d      = in_idx_q;
    frame_count_d = frame_count_q;

    if (s_hs) begin
      in_idx_d = (in_idx_q == LastIdx) ? '0 : in_idx_q + OneIdx;
    end

    if (m_hs) begin
      if (out_last) begin
        out_idx_d     = '0;
        state_d       = (state_q == StPing) ? StPong : StPing;
        frame_count_d = frame_count_q + CW'(1);
      end else begin
        out_idx_d = out_idx_q + OneIdx;
      end
    end

    // Registered ready for next cycle: block at a frame boundary while disabled.
    hold = (in_idx_d == '0) && !enable;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= StPing;
      out_idx_q     <= '0;
      in_idx_q      <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      out_idx_q     <= out_idx_d;
      in_idx_q      <= in_idx_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Output demux: only the selected path sees valid/data/tlast.
  always_comb begin
    m0_axis_tvalid = 1'b0;
    m0_axis_tlast  = 1'b0;
    m0_axis_tdata  = '0;
    m1_axis_tvalid = 1'b0;
    m1_axis_tlast  = 1'b0;
    m1_axis_tdata  = '0;
    path_sel       = PATH_PING;
    unique case (state_q)
      StPing: begin
        path_sel       = PATH_PING;
        m0_axis_tvalid = buf_valid;
        m0_axis_tlast  = buf_valid && out_last;
        m0_axis_tdata  = buf_data;
      end
      StPong: begin
        path_sel       = PATH_PONG;
        m1_axis_tvalid = buf_valid;
        m1_axis_tlast  = buf_valid && out_last;
        m1_axis_tdata  = buf_data;
      end
      default: ;
    endcase
  end

  assign active_path = path_sel;
  assign frame_count = frame_count_q;
  assign in_beat_idx = in_idx_q;

endmodule

// File: tb/tb_stream_frame_router.sv
module tb_stream_frame_router;

  localparam int unsigned DW = 128;
  localparam int unsigned FS = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m0_tdata, m1_tdata;
  logic          m0_tvalid, m1_tvalid, m0_tlast, m1_tlast;
  logic          m0_tready = 1'b1;
  logic          m1_tready = 1'b1;
  logic          active_path;
  logic [CW-1:0] frame_count;
  logic [1:0]    in_beat_idx;

  int tests = 0;
  int fails = 0;
  int exp_k = 0;
  logic [DW:0] q0[$];
  logic [DW:0] q1[$];

  stream_frame_router #(
    .DW(DW),
    .FRAME_SIZE(FS),
    .CW(CW)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .enable        (enable),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m0_axis_tdata (m0_tdata),
    .m0_axis_tvalid(m0_tvalid),
    .m0_axis_tlast (m0_tlast),
    .m0_axis_tready(m0_tready),
    .m1_axis_tdata (m1_tdata),
    .m1_axis_tvalid(m1_tvalid),
    .m1_axis_tlast (m1_tlast),
    .m1_axis_tready(m1_tready),
    .active_path   (active_path),
    .frame_count   (frame_count),
    .in_beat_idx   (in_beat_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int v);
    return {4{32'(v) ^ 32'hA500_0000}};
  endfunction

  // Scoreboard monitor: every presented beat must match the queue head.
  always @(negedge clk) begin
    if (resetn) begin
      if (m0_tvalid && m1_tvalid) begin
        tests++;
        fails++;
        $display("FAIL both paths valid: got m0=1 m1=1, expected one at most");
      end
      if (m0_tvalid) begin
        if (q0.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL m0 unexpected beat: got %0h, expected none", m0_tdata);
        end else begin
          check("m0 beat {tlast,tdata}", {m0_tlast, m0_tdata}, q0[0]);
          if (m0_tready) void'(q0.pop_front());
        end
      end
      if (m1_tvalid) begin
        if (q1.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL m1 unexpected beat: got %0h, expected none", m1_tdata);
        end else begin
          check("m1 beat {tlast,tdata}", {m1_tlast, m1_tdata}, q1[0]);
          if (m1_tready) void'(q1.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, output int waits);
    logic        last_b;
    logic [DW:0] e;
    waits    = 0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!s_tready) begin
      tests++;
      fails++;
      $display("FAIL send timeout: tready=0 after %0d cycles, expected 1", waits);
      s_tvalid = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    #1;
    last_b = ((exp_k % FS) == FS - 1);
    e = {last_b, d};
    if (((exp_k / FS) % 2) == 0) q0.push_back(e);
    else q1.push_back(e);
    exp_k++;
    s_tvalid = 1'b0;
  endtask

  task automatic send_n(input int base, input int n, output int total);
    int w;
    total = 0;
    for (int i = 0; i < n; i++) begin
      send(pat(base + i), w);
      total += w;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d beats undelivered, expected 0", q0.size() + q1.size());
      q0.delete();
      q1.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic status(input string name, input int fc, input logic ap);
    check({name, " frame_count"}, frame_count, fc);
    check({name, " active_path"}, active_path, ap);
  endtask

  task automatic rst_seq();
    resetn   = 1'b0;
    enable   = 1'b1;
    s_tvalid = 1'b0;
    q0.delete();
    q1.delete();
    exp_k = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst valid/tlast", {m0_tvalid, m1_tvalid, m0_tlast, m1_tlast}, 0);
    check("rst tdata", m0_tdata | m1_tdata, 0);
    check("rst tready", s_tready, 0);
    check("rst in_beat_idx", in_beat_idx, 0);
    status("rst", 0, 1'b0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check("first cycle after release tready", s_tready, 0);
    @(posedge clk);
    @(negedge clk);
    check("second cycle after release tready", s_tready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    #1;
    // 1: back-to-back ping/pong frames, first-beat latency
    rst_seq();
    fork
      send_n(0, 8, w);
      begin
        int n = 0;
        @(negedge clk);
        while (!(s_tvalid && s_tready) && n < 20) begin
          n++;
          @(negedge clk);
        end
        @(negedge clk);
        check("t1 latency m0_tvalid", m0_tvalid, 1);
      end
    join
    check("t1 input stalls", w, 0);
    drain();
    status("t1", 2, 1'b0);

    // 2: m0 stalled 5 cycles mid-frame
    fork
      send_n(8, 8, w);
      begin
        int acc = 0;
        repeat (2) @(posedge clk);
        #1;
        m0_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (s_tvalid && s_tready) acc++;
          check("t2 m0_tvalid held", m0_tvalid, 1);
        end
        check("t2 tready low in stall", s_tready, 0);
        tests++;
        if (acc > 2) begin
          fails++;
          $display("FAIL t2 beats accepted in stall: got %0d, expected <= 2", acc);
        end
        @(posedge clk);
        #1;
        m0_tready = 1'b1;
      end
    join
    drain();
    status("t2", 4, 1'b0);

    // 3: enable dropped on beat 1 of a frame
    fork
      send_n(16, 8, w);
      begin
        int n = 0;
        @(negedge clk);
        while (in_beat_idx != 2'd1 && n < 50) begin
          n++;
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        enable = 1'b0;
        n = 0;
        @(negedge clk);
        while (in_beat_idx != 2'd0 && n < 50) begin
          n++;
          @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
          check("t3 gated tready", s_tready, 0);
          check("t3 in_beat_idx at boundary", in_beat_idx, 0);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t3 tready resumes", s_tready, 1);
      end
    join
    drain();
    status("t3", 6, 1'b0);

    // 4: m1_tready toggling during a ping frame
    fork
      send_n(24, 4, w);
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1;
        m1_tready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("t4 m1_tvalid idle", m1_tvalid, 0);
      end
    join
    m1_tready = 1'b1;
    drain();
    status("t4", 7, 1'b1);

    // 5: reset pulsed after 2 beats of frame 0
    rst_seq();
    send_n(100, 2, w);
    rst_seq();
    send_n(200, 4, w);
    drain();
    status("t5", 1, 1'b1);

    // 6: frame_count wrap with CW=4
    rst_seq();
    send_n(300, 60, w);
    drain();
    status("t6 15 frames", 15, 1'b1);
    send_n(400, 4, w);
    drain();
    status("t6 16 frames", 0, 1'b0);
    send_n(500, 4, w);
    drain();
    status("t6 17 frames", 1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
